seg_serial_rx: RTL and testbench

- Receiving end of the board's serial display/LED shift-out link (serial clock, serial data, active-low clear, PEN latch strobe).
- Reconstructs the shifted frame as a parallel word, the same way the on-board shift-register chain does.
- Used for loop-back self-test of the seven-segment and LED drivers, and as a bench checker on the FPGA.
- Runs on the 100 MHz system clock and oversamples the much slower serial clock.

---
 rtl/seg_serial_rx.sv | 191 +++++++++++++++++++
 tb/tb_seg_serial_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_rx.sv
// seg_serial_rx
//   Receiving end of the serial display/LED shift-out link. Oversamples the
//   serial clock, data, clear and latch strobe on the system clock and
//   rebuilds each shifted frame as a parallel word, the same way the
//   on-board shift-register chain does. The first bit shifted in ends up in
//   the MSB of frame_data.
//
// Parameters
//   FRAME_BITS   bits per complete frame (8..64)
//   SYNC_STAGES  synchronizer depth on every serial input (>= 2)
//
// Ports
//   clk          system clock
//   RSTN         asynchronous active-low reset, clears all state
//   s_clk        serial shift clock (asynchronous to clk)
//   s_dat        serial data, valid at the rising edge of s_clk
//   s_clrn       active-low chain clear
//   s_pen        latch strobe, rising edge ends a frame
//   frame_ack    one-cycle pulse, clears frame_valid
//   frame_data   last latched frame
//   frame_valid  a new frame is held and not yet acknowledged
//   bit_cnt      bits received in the current frame, saturates at 127
//   err_len      sticky: strobe arrived while bit_cnt != FRAME_BITS
//   err_ovr      sticky: frame latched while frame_valid was still high
//
// Build option
//   SEG_RX_GLITCH_FILTER_EN  when defined, each synchronized input must hold
//                            a new level for 3 consecutive clk cycles before
//                            it is accepted (adds 2 cycles of edge latency).
module seg_serial_rx #(
  parameter int unsigned FRAME_BITS  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  s_clk,
  input  logic                  s_dat,
  input  logic                  s_clrn,
  input  logic                  s_pen,
  input  logic                  frame_ack,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic [6:0]            bit_cnt,
  output logic                  err_len,
  output logic                  err_ovr
);

  localparam logic [6:0] FRAME_CNT = 7'(FRAME_BITS);
  localparam logic [6:0] CNT_MAX   = 7'd127;

  // Bit positions of the serial inputs inside the synchronizer vectors.
  localparam int unsigned I_CLK  = 0;
  localparam int unsigned I_DAT  = 1;
  localparam int unsigned I_CLRN = 2;
  localparam int unsigned I_PEN  = 3;

  logic [3:0] raw_in;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_last;
  logic [3:0] lvl;

  assign raw_in    = {s_pen, s_clrn, s_dat, s_clk};
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef SEG_RX_GLITCH_FILTER_EN
  logic [3:0] hist0_q, hist1_q, filt_q;
  logic [3:0] agree;
  logic [3:0] filt_d;

  // A level is accepted in the cycle its third consecutive sample arrives;
  // the accepted level is used combinationally so the added latency is
  // exactly two cycles.
  always_comb begin
    agree  = ~(sync_last ^ hist0_q) & ~(hist0_q ^ hist1_q);
    filt_d = (agree & sync_last) | (~agree & filt_q);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      hist0_q <= sync_last;
      hist1_q <= hist0_q;
      filt_q  <= filt_d;
    end
  end

  assign lvl = filt_d;
`else
  assign lvl = sync_last;
`endif

  // Edge detection against one extra registered stage.
  logic clk_prev_q, pen_prev_q;
  logic clk_rise, pen_rise;

  assign clk_rise = lvl[I_CLK] & ~clk_prev_q;
  assign pen_rise = lvl[I_PEN] & ~pen_prev_q;

  logic [FRAME_BITS-1:0] shreg_q, shreg_d, shift_val;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [6:0]            cnt_q, cnt_d, cnt_val;
  logic                  valid_q, valid_d;
  logic                  el_q, el_d;
  logic                  eo_q, eo_d;

  always_comb begin
    // Shift is applied first so a coincident strobe sees the shifted word.
    shift_val = clk_rise ? {shreg_q[FRAME_BITS-2:0], lvl[I_DAT]} : shreg_q;
    cnt_val   = cnt_q;
    if (clk_rise && cnt_q != CNT_MAX) begin
      cnt_val = cnt_q + 7'd1;
    end

    shreg_d = shift_val;
    cnt_d   = cnt_val;
    data_d  = data_q;
    valid_d = valid_q;
    el_d    = el_q;
    eo_d    = eo_q;

    if (frame_ack && valid_q) begin
      valid_d = 1'b0;
    end

    if (!lvl[I_CLRN]) begin
      // Clear dominates; a strobe during clear is a short frame.
      shreg_d = '0;
      cnt_d   = '0;
      if (pen_rise) begin
        el_d = 1'b1;
      end
    end else if (pen_rise) begin
      cnt_d = '0;
      if (cnt_val == FRAME_CNT) begin
        data_d  = shift_val;
        valid_d = 1'b1;
        // An acknowledge in the same cycle consumes the old frame.
        if (valid_q && !frame_ack) begin
          eo_d = 1'b1;
        end
      end else begin
        el_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      clk_prev_q <= 1'b0;
      pen_prev_q <= 1'b0;
      shreg_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      el_q       <= 1'b0;
      eo_q       <= 1'b0;
    end else begin
      clk_prev_q <= lvl[I_CLK];
      pen_prev_q <= lvl[I_PEN];
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      el_q       <= el_d;
      eo_q       <= eo_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign bit_cnt     = cnt_q;
  assign err_len     = el_q;
  assign err_ovr     = eo_q;

endmodule

// File: tb/tb_seg_serial_rx.sv
// Bench for seg_serial_rx: randomized and directed serial frames, with a
// frame-level reference model feeding an expectation queue that a separate
// monitor drains and compares against the DUT outputs.
module tb_seg_serial_rx;

  localparam int unsigned FB = 64;

  logic          clk;
  logic          RSTN;
  logic          s_clk, s_dat, s_clrn, s_pen, frame_ack;
  logic [FB-1:0] frame_data;
  logic          frame_valid;
  logic [6:0]    bit_cnt;
  logic          err_len, err_ovr;

  seg_serial_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .RSTN        (RSTN),
    .s_clk       (s_clk),
    .s_dat       (s_dat),
    .s_clrn      (s_clrn),
    .s_pen       (s_pen),
    .frame_ack   (frame_ack),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .bit_cnt     (bit_cnt),
    .err_len     (err_len),
    .err_ovr     (err_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void cmp(string nm, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // ---------------- reference model (frame level) ----------------
  bit          mbits[$];   // last FB bits shifted since the last clear
  int unsigned mcnt;       // bits in current frame, saturating at 127
  logic [63:0] mdata;
  logic        mvalid, mel, meo;

  function automatic void m_reset();
    mbits.delete();
    mcnt = 0; mdata = '0; mvalid = 0; mel = 0; meo = 0;
  endfunction

  function automatic void m_shift(bit b);
    mbits.push_back(b);
    if (mbits.size() > FB) void'(mbits.pop_front());
    if (mcnt < 127) mcnt++;
  endfunction

  function automatic void m_latch();
    logic [63:0] w;
    if (mcnt == FB) begin
      w = '0;
      foreach (mbits[i]) w = {w[62:0], mbits[i]};
      if (mvalid) meo = 1'b1;
      mvalid = 1'b1;
      mdata  = w;
    end else begin
      mel = 1'b1;
    end
    mcnt = 0;
  endfunction

  function automatic void m_clear();
    mbits.delete();
    mcnt = 0;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [63:0] data;
    logic        valid, el, eo;
    logic [6:0]  cnt;
    int unsigned due;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push_exp(string nm, int unsigned delay);
    exp_t e;
    e.name = nm; e.data = mdata; e.valid = mvalid; e.el = mel; e.eo = meo;
    e.cnt = 7'(mcnt); e.due = cyc + delay;
    exp_q.push_back(e);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        e = exp_q.pop_front();
        cmp({e.name, ".data"},  frame_data,  e.data);
        cmp({e.name, ".valid"}, 64'(frame_valid), 64'(e.valid));
        cmp({e.name, ".cnt"},   64'(bit_cnt),  64'(e.cnt));
        cmp({e.name, ".elen"},  64'(err_len),  64'(e.el));
        cmp({e.name, ".eovr"},  64'(err_ovr),  64'(e.eo));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b, int half, bit glitch);
    s_dat = b;
    if (glitch) begin
      wait_cyc(2);
      s_clk = 1'b1;
      wait_cyc(1);
      s_clk = 1'b0;
      wait_cyc(half - 3);
    end else begin
      wait_cyc(half);
    end
    s_clk = 1'b1;
    m_shift(b);
    wait_cyc(half);
    s_clk = 1'b0;
  endtask

  // n bits taken from v, most significant of the n first
  task automatic send_bits(logic [63:0] v, int n, int half, bit glitch);
    for (int i = 0; i < n; i++) begin
      send_bit(v[(n - 1 - i) % 64], half, glitch && (i % 7 == 3));
    end
  endtask

  task automatic pen_pulse(string nm);
    s_pen = 1'b1;
    m_latch();
    push_exp(nm, 10);
    wait_cyc(6);
    s_pen = 1'b0;
    wait_cyc(6);
  endtask

  task automatic ack_pulse(string nm);
    frame_ack = 1'b1;
    wait_cyc(1);
    frame_ack = 1'b0;
    if (mvalid) mvalid = 1'b0;
    push_exp(nm, 4);
    wait_cyc(6);
  endtask

  task automatic idle_check(string nm);
    push_exp(nm, 8);
    wait_cyc(12);
  endtask

  task automatic clear_pulse(int n);
    s_clrn = 1'b0;
    m_clear();
    push_exp("clear", 8);
    wait_cyc(n);
    s_clrn = 1'b1;
    wait_cyc(8);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic async_reset_check(string nm);
    drain();
    @(posedge clk);
    #3;
    RSTN = 1'b0;
    #1;
    cmp({nm, ".data"},  frame_data, 64'h0);
    cmp({nm, ".valid"}, 64'(frame_valid), 64'h0);
    cmp({nm, ".cnt"},   64'(bit_cnt), 64'h0);
    cmp({nm, ".elen"},  64'(err_len), 64'h0);
    cmp({nm, ".eovr"},  64'(err_ovr), 64'h0);
    s_clk = 1'b0; s_dat = 1'b0; s_pen = 1'b0; s_clrn = 1'b1; frame_ack = 1'b0;
    m_reset();
    wait_cyc(3);
    RSTN = 1'b1;
    wait_cyc(10);
    idle_check({nm, ".after"});
  endtask

  initial begin : stim
    logic [63:0] v;
    int          n;
    bit          gl;
    RSTN = 1'b0; s_clk = 1'b0; s_dat = 1'b0; s_clrn = 1'b1; s_pen = 1'b0;
    frame_ack = 1'b0;
    m_reset();
    wait_cyc(3);
    RSTN = 1'b1;
    wait_cyc(10);
    idle_check("reset");

    // normal frame at 1 MHz serial clock
    send_bits(64'hDEAD_BEEF_0123_4567, 64, 50, 1'b0);
    idle_check("normal_cnt");
    pen_pulse("normal");
    ack_pulse("normal_ack");

    // clear mid-frame, then a fresh all-ones frame
    send_bits(64'h1234_5678_9ABC_DEF0, 30, 5, 1'b0);
    idle_check("pre_clear_cnt");
    clear_pulse(10);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64, 5, 1'b0);
    pen_pulse("ones");
    ack_pulse("ones_ack");

    // 64th s_clk rise and s_pen rise together
    v = 64'hA5C3_0F96_1E2D_3C4B;
    send_bits(v, 63, 5, 1'b0);
    s_dat = v[0];
    wait_cyc(5);
    s_clk = 1'b1; s_pen = 1'b1;
    m_shift(v[0]);
    m_latch();
    push_exp("coincident", 10);
    wait_cyc(6);
    s_clk = 1'b0; s_pen = 1'b0;
    wait_cyc(6);
    ack_pulse("coincident_ack");

    // short frame
    send_bits(64'h0000_00AB_CDEF_0123, 40, 5, 1'b0);
    pen_pulse("short");

    // overrun
    send_bits(64'h0000_0000_0000_0001, 64, 5, 1'b0);
    pen_pulse("ovr1");
    send_bits(64'h0000_0000_0000_0002, 64, 5, 1'b0);
    pen_pulse("ovr2");
    ack_pulse("ovr_ack");
    ack_pulse("ack_idle");

    // count saturation, then a strobe on the saturated count
    send_bits({$urandom, $urandom}, 130, 3, 1'b0);
    idle_check("sat_cnt");
    pen_pulse("sat_pen");

    // randomized frames
    for (int k = 0; k < 10; k++) begin
      v = {$urandom, $urandom};
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 80)) : 64;
      send_bits(v, n, int'($urandom_range(3, 6)), 1'b0);
      if ($urandom_range(0, 3) == 0) clear_pulse(int'($urandom_range(2, 12)));
      pen_pulse("rand");
      if ($urandom_range(0, 1) == 1) ack_pulse("rand_ack");
    end

    // asynchronous reset mid-frame, then a full frame
    send_bits({$urandom, $urandom}, 20, 5, 1'b0);
    async_reset_check("async_rst");
`ifdef SEG_RX_GLITCH_FILTER_EN
    gl = 1'b1;
`else
    gl = 1'b0;
`endif
    send_bits(64'hC0FF_EE00_1357_9BDF, 64, 5, gl);
    idle_check("post_rst_cnt");
    pen_pulse("post_rst");

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
